apb_slave_regbank: RTL and testbench

APB_SLAVE_REGBANK -- requirements
Module: apb_slave_regbank

---
 rtl/apb_slave_regbank.sv | 147 ++++++++++++++
 tb/tb_apb_slave_regbank.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regbank.sv
// APB slave register bank: NUM_REGS word registers with byte strobes,
// a fixed number of wait states and PSLVERR on out-of-range addresses.
module apb_slave_regbank #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter int unsigned              NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 'h10,
  parameter int unsigned              WAIT_STATES   = 1
) (
  input  logic                      S_CLK,
  input  logic                      RSTn,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [ADDRESS_WIDTH-1:0]  PADDR,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic [DATA_WIDTH/8-1:0]   PSTRB,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  state_e                   state_q;
  logic [3:0]               cnt_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     write_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [STRB_W-1:0]        strb_q;
  logic [DATA_WIDTH-1:0]    regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]    prdata_q;
  logic                     pready_q;
  logic                     pslverr_q;

  logic [ADDRESS_WIDTH-1:0] acc_addr;
  logic [ADDRESS_WIDTH-1:0] acc_off;
  logic                     acc_write;
  logic                     acc_valid;
  logic [IDX_W-1:0]         acc_idx;
  logic                     start;
  logic                     enter_done;
  logic                     commit;
  logic [DATA_WIDTH-1:0]    wr_merge_d;

  // In IDLE the setup is decoded straight from the bus so a zero-wait
  // transfer can enter DONE on the same edge that latches it.
  always_comb begin
    acc_addr   = (state_q == IDLE) ? PADDR : addr_q;
    acc_write  = (state_q == IDLE) ? PWRITE : write_q;
    acc_off    = acc_addr - BASE_ADDR;
    acc_valid  = (acc_addr >= BASE_ADDR) && (acc_off < ADDRESS_WIDTH'(NUM_REGS));
    acc_idx    = acc_off[IDX_W-1:0];
    start      = (state_q == IDLE) && PSEL && !PENABLE;
    enter_done = (start && (WAIT_STATES == 0)) ||
                 ((state_q == WAIT) && PSEL && (cnt_q == 4'd1));
    commit     = (state_q == DONE) && PSEL && write_q && acc_valid;
  end

  always_comb begin
    wr_merge_d = regs_q[acc_idx];
    for (int b = 0; b < STRB_W; b++) begin
      if (strb_q[b]) begin
        wr_merge_d[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge S_CLK) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[acc_idx] <= wr_merge_d;
    end
  end

  // Outputs default to zero every cycle and are only raised on entry to DONE.
  always_ff @(posedge S_CLK) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      if (enter_done) begin
        pready_q  <= 1'b1;
        pslverr_q <= !acc_valid;
        prdata_q  <= (acc_valid && !acc_write) ? regs_q[acc_idx] : '0;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            if (WAIT_STATES == 0) begin
              state_q <= DONE;
            end else begin
              cnt_q   <= 4'(WAIT_STATES);
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: one instance with one wait state, one with none,
// both checked against an array model of the register file.
module tb_apb_slave_regbank;

  localparam logic [31:0] BASE  = 32'h10;
  localparam int          NREGS = 16;

  logic        clk = 1'b0;
  logic        rstn    [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  logic [31:0] model [2][NREGS];
  int          readyCycle [2];
  int          compared   = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  apb_slave_regbank #(.WAIT_STATES(1)) dut0 (
    .S_CLK(clk), .RSTn(rstn[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  apb_slave_regbank #(.WAIT_STATES(0)) dut1 (
    .S_CLK(clk), .RSTn(rstn[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one APB transfer starting now (just after a rising edge) and
  // returns once the slave is back in IDLE. Cycle numbering: setup is cycle 0.
  task automatic applyStimulus(input int d, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               output logic [31:0] rdata, output logic err,
                               output int rdyCyc, output bit quiet);
    rdyCyc = -1;
    quiet  = 1'b1;
    rdata  = '0;
    err    = 1'b0;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = data; pstrb[d] = strb;
    for (int k = 1; k <= 20 && rdyCyc < 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        penable[d] = 1'b1;
        paddr[d]   = $urandom;
        pwdata[d]  = $urandom;
      end
      if (pready[d] === 1'b1) begin
        rdyCyc = k;
        rdata  = prdata[d];
        err    = pslverr[d];
      end else if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) begin
        quiet = 1'b0;
      end
    end
    @(posedge clk); #1;
    if (pready[d] !== 1'b0 || prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) quiet = 1'b0;
  endtask

  task automatic runXfer(input int d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, input string tag);
    logic [31:0] rd;
    logic        er;
    int          cyc;
    bit          quiet;
    bit          valid;
    int          idx;
    logic [31:0] expData;
    valid   = (addr >= BASE) && ((addr - BASE) < NREGS);
    idx     = valid ? int'(addr - BASE) : 0;
    expData = (valid && !wr) ? model[d][idx] : 32'h0;
    applyStimulus(d, wr, addr, data, strb, rd, er, cyc, quiet);
    checkOutput({tag, "_rdycyc"}, 32'(cyc), 32'(readyCycle[d]));
    checkOutput({tag, "_slverr"}, {31'h0, er}, {31'h0, !valid});
    checkOutput({tag, "_quiet"}, {31'h0, quiet}, 32'h1);
    if (!wr || !valid) checkOutput({tag, "_rdata"}, rd, expData);
    if (wr && valid) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[d][idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic idleCycles(input int d, input int n);
    psel[d] = 1'b0; penable[d] = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before end of stimulus");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          ok;
    logic [31:0] a;
    readyCycle[0] = 2;
    readyCycle[1] = 1;
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
      for (int r = 0; r < NREGS; r++) model[d][r] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset_pready_d%0d", d), {31'h0, pready[d]}, 32'h0);
      checkOutput($sformatf("reset_prdata_d%0d", d), prdata[d], 32'h0);
      checkOutput($sformatf("reset_pslverr_d%0d", d), {31'h0, pslverr[d]}, 32'h0);
      rstn[d] = 1'b1;
    end
    @(posedge clk); #1;

    runXfer(0, 1'b1, 32'h10, 32'hABCD1234, 4'hF, "wr10");
    runXfer(0, 1'b0, 32'h10, 32'h0, 4'h0, "rd10");

    runXfer(0, 1'b1, 32'h11, 32'hBCDA1234, 4'hF, "wr11_full");
    runXfer(0, 1'b1, 32'h11, 32'hFFFFFFFF, 4'h1, "wr11_byte0");
    runXfer(0, 1'b0, 32'h11, 32'h0, 4'h0, "rd11");
    checkOutput("model11", model[0][1], 32'hBCDA12FF);

    runXfer(0, 1'b0, 32'h20, 32'h0, 4'h0, "rd20_oob");
    runXfer(0, 1'b1, 32'h0F, 32'h5A5A5A5A, 4'hF, "wr0f_oob");
    runXfer(0, 1'b1, 32'hFFFF_0010, 32'h5A5A5A5A, 4'hF, "wr_far_oob");

    runXfer(1, 1'b1, 32'h10, 32'h13572468, 4'hF, "ws0_wr10");
    runXfer(1, 1'b0, 32'h10, 32'h0, 4'h0, "ws0_rd10");

    // Master abandons a write during its wait cycle.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h12; pwdata[0] = 32'h55AA55AA; pstrb[0] = 4'hF;
    @(posedge clk); #1;
    psel[0] = 1'b0;
    ok = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (pready[0] !== 1'b0) ok = 1'b0;
    end
    checkOutput("abort_no_ready", {31'h0, ok}, 32'h1);
    runXfer(0, 1'b0, 32'h12, 32'h0, 4'h0, "abort_rd12");

    // Access phase without a setup phase must be ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 32'h10; pwdata[0] = 32'hFFFFFFFF; pstrb[0] = 4'hF;
    ok = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (pready[0] !== 1'b0) ok = 1'b0;
    end
    checkOutput("no_setup_ignored", {31'h0, ok}, 32'h1);
    idleCycles(0, 1);
    runXfer(0, 1'b0, 32'h10, 32'h0, 4'h0, "no_setup_rd10");

    // Reset lands while the write to 0x13 sits in DONE.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h13; pwdata[0] = 32'hDEADBEEF; pstrb[0] = 4'hF;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_done_ready", {31'h0, pready[0]}, 32'h1);
    rstn[0] = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_pready", {31'h0, pready[0]}, 32'h0);
    checkOutput("rst_prdata", prdata[0], 32'h0);
    checkOutput("rst_pslverr", {31'h0, pslverr[0]}, 32'h0);
    rstn[0] = 1'b1;
    for (int r = 0; r < NREGS; r++) model[0][r] = '0;
    idleCycles(0, 1);
    runXfer(0, 1'b0, 32'h13, 32'h0, 4'h0, "rst_rd13");
    runXfer(0, 1'b0, 32'h10, 32'h0, 4'h0, "rst_rd10");

    for (int i = 0; i < 60; i++) begin
      int d;
      d = i % 2;
      a = BASE - 32'd3 + 32'($urandom_range(0, NREGS + 5));
      runXfer(d, 1'($urandom), a, $urandom, 4'($urandom), $sformatf("rand%0d", i));
      if ($urandom_range(0, 2) == 0) idleCycles(d, 1);
    end

    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < NREGS; r++) begin
        runXfer(d, 1'b0, BASE + 32'(r), 32'h0, 4'h0, $sformatf("final_d%0d_r%0d", d, r));
      end
      idleCycles(d, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
